// File: rtl/rv32i_types.sv
// Shared RV32I/M types: machine word, M-extension funct3 codes and divider state.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int unsigned DIV_ITERS = 32;

  // Read as unsigned, 32'h8000_0000 negates to itself, which is exactly 2^31.
  function automatic rv32i_word abs_word(input rv32i_word w, input logic sgn);
    return (sgn && w[31]) ? (~w + 32'd1) : w;
  endfunction

endpackage

// File: rtl/rv32m_divider_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract, restore.
module div_step
  import rv32i_types::*;
(
  input  logic [32:0] rem_in,
  input  logic [32:0] divisor,
  input  logic        dbit,
  output logic [32:0] rem_out,
  output logic        qbit
);

  logic [33:0] shifted;
  logic [33:0] trial;

  always_comb begin
    shifted = {rem_in, dbit};
    trial   = shifted - {1'b0, divisor};
    qbit    = ~trial[33];
    rem_out = qbit ? trial[32:0] : shifted[32:0];
  end

endmodule

// File: rtl/rv32m_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU with a fast path for
// divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | one restoring step per cycle, 32 cycles
// FIN   | sign correction, result registered
// DONE  | one-cycle done pulse, result valid
module rv32m_divider
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      flush,
  input  logic [2:0] funct3,
  input  rv32i_word a,
  input  rv32i_word b,
  output logic      busy,
  output logic      done,
  output rv32i_word result
);

  localparam int unsigned CNT_W = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [32:0]      rem_q;
  logic [32:0]      dsr_q;
  rv32i_word        dvd_q;
  logic             neg_quo, neg_rem, is_rem_q;

  m_funct3_t op_in;
  logic      sgn_in, is_rem_in, b_zero, ovf, fast, accept;
  rv32i_word a_mag, b_mag, special, quo_fix, rem_fix;
  logic [32:0] step_rem;
  logic        step_q;

  always_comb begin
    op_in     = m_funct3_t'(funct3);
    sgn_in    = (op_in == M_DIV) || (op_in == M_REM);
    is_rem_in = (op_in == M_REM) || (op_in == M_REMU);
    a_mag     = abs_word(a, sgn_in);
    b_mag     = abs_word(b, sgn_in);
    b_zero    = (b == 32'd0);
    ovf       = sgn_in && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    fast      = b_zero || ovf;
    accept    = (state == IDLE) && start && !flush;
    if (is_rem_in) special = b_zero ? a : 32'd0;
    else           special = b_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
  end

  div_step u_step (
    .rem_in  (rem_q),
    .divisor (dsr_q),
    .dbit    (dvd_q[31]),
    .rem_out (step_rem),
    .qbit    (step_q)
  );

  // After the last step dvd_q has been fully replaced by quotient bits.
  always_comb begin
    quo_fix = neg_quo ? (~dvd_q + 32'd1) : dvd_q;
    rem_fix = neg_rem ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_nxt = fast ? DONE : CALC;
        CALC: if (count == CNT_LAST) state_nxt = FIN;
        FIN:  state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      dvd_q    <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      is_rem_q <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count    <= '0;
            rem_q    <= '0;
            dsr_q    <= {1'b0, b_mag};
            dvd_q    <= a_mag;
            neg_quo  <= sgn_in && (a[31] ^ b[31]);
            neg_rem  <= sgn_in && a[31];
            is_rem_q <= is_rem_in;
            if (fast) result <= special;
          end
        end
        CALC: begin
          if (!flush) begin
            rem_q <= step_rem;
            dvd_q <= {dvd_q[30:0], step_q};
            count <= count + 1'b1;
          end
        end
        FIN: begin
          if (!flush) result <= is_rem_q ? rem_fix : quo_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC) || (state == FIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rv32m_divider.sv
// Directed bench for rv32m_divider: latency, busy span, results, flush, ignored start, async reset.
module tb_rv32m_divider;

  logic        clk, rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] a, b, result;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  rv32m_divider #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after acceptance, then check latency, busy span and result.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp, input int lat);
    int n, bcnt;
    funct3 = f; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
    n = 1; bcnt = 0;
    while (!done && n < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy cycles"}, bcnt, lat - 1);
    chk({tag, " result"}, result, exp);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, {31'b0, done}, 32'd0);
    chk({tag, " result hold"}, result, exp);
  endtask

  initial begin
    int n, dcnt;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("divu 20/3", 3'b101, 32'd20, 32'd3, 32'd6, 34);
    run_op("remu 20/3", 3'b111, 32'd20, 32'd3, 32'd2, 34);
    run_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("rem 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run_op("divu 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem 5/0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("div min/2", 3'b100, 32'h8000_0000, 32'd2, 32'hC000_0000, 34);

    // Start pulse mid-operation must be ignored, not queued.
    funct3 = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if (n == 10) begin start = 1'b1; a = 32'd50; b = 32'd5; funct3 = 3'b100; end
      else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("ignored start latency", n, 34);
    chk("ignored start result", result, 32'd14);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("no queued op", dcnt, 0);

    // Flush at cycle 20 of a second op.
    funct3 = 3'b101; a = 32'd9999; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush done", {31'b0, done}, 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("flush stays idle", dcnt, 0);
    chk("flush keeps result", result, 32'd14);

    // Flush and start together in IDLE: nothing accepted.
    funct3 = 3'b101; a = 32'd8; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy", {31'b0, busy}, 32'd0);
    chk("flush+start done", {31'b0, done}, 32'd0);

    // Asynchronous reset mid-CALC.
    funct3 = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    chk("pre-reset busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst busy", {31'b0, busy}, 32'd0);
    chk("async rst done", {31'b0, done}, 32'd0);
    chk("async rst result", result, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("divu 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
